// File: rtl/mainfsm_pkg.sv
// Shared types and constants for the multicycle RV32I+F control FSM.
package mainfsm_pkg;

    localparam int unsigned OP_W  = 7;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_LUI      = 4'd11,
        S_FPEXEC   = 4'd12,
        S_FPWB     = 4'd13,
        S_ILLEGAL  = 4'd14
    } state_t;

    localparam logic [OP_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_FLW   = 7'b0000111;
    localparam logic [OP_W-1:0] OP_STORE = 7'b0100011;
    localparam logic [OP_W-1:0] OP_FSW   = 7'b0100111;
    localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;
    localparam logic [OP_W-1:0] OP_LUI   = 7'b0110111;
    localparam logic [OP_W-1:0] OP_FP    = 7'b1010011;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;
    localparam logic [SEL_W-1:0] SRCA_ZERO  = 2'b11;

    typedef struct packed {
        logic             pc_update;
        logic             ir_write;
        logic             reg_write;
        logic             freg_write;
        logic             mem_write;
        logic             branch;
        logic             adr_src;
        logic             fp_start;
        logic [SEL_W-1:0] result_src;
        logic [SEL_W-1:0] alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic             illegal;
    } ctrl_t;

    // Moore decode; FETCH strobes are later qualified by MemReady, fp_start by entry.
    function automatic ctrl_t state_ctrl(state_t s, logic [OP_W-1:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.pc_update = 1'b1; c.ir_write = 1'b1; c.result_src = 2'b10;
                c.alu_src_a = SRCA_PC; c.alu_src_b = 2'b10;
            end
            S_DECODE:   begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = 2'b01; end
            S_MEMADR:   begin c.alu_src_a = SRCA_RS1;   c.alu_src_b = 2'b01; end
            S_MEMREAD:  c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = 2'b01;
                if (op == OP_FLW) c.freg_write = 1'b1;
                else              c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
            S_EXECUTER: begin c.alu_src_a = SRCA_RS1; c.alu_src_b = 2'b00; c.alu_op = 2'b10; end
            S_EXECUTEI: begin c.alu_src_a = SRCA_RS1; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
            S_LUI:      begin c.alu_src_a = SRCA_ZERO; c.alu_src_b = 2'b01; end
            S_ALUWB:    c.reg_write = 1'b1;
            S_JAL:      begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
            S_BEQ: begin
                c.alu_src_a = SRCA_RS1; c.alu_src_b = 2'b00; c.alu_op = 2'b01; c.branch = 1'b1;
            end
            S_FPEXEC:   begin c.alu_src_a = SRCA_RS1; c.alu_src_b = 2'b00; c.alu_op = 2'b11; end
            S_FPWB:     c.freg_write = 1'b1;
            S_ILLEGAL:  c.illegal = 1'b1;
            default:    c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mainfsm_if.sv
// Control bundle between the main FSM (slave) and the datapath/memory side (master).
interface mainfsm_if;
    import mainfsm_pkg::*;

    logic [OP_W-1:0]  op;
    logic             MemReady;
    logic             FpDone;
    logic             PCUpdate;
    logic             IRWrite;
    logic             RegWrite;
    logic             FRegWrite;
    logic             MemWrite;
    logic             Branch;
    logic             AdrSrc;
    logic             FpStart;
    logic [SEL_W-1:0] ResultSrc;
    logic [SEL_W-1:0] ALUSrcA;
    logic [SEL_W-1:0] ALUSrcB;
    logic [SEL_W-1:0] ALUOp;
    logic             Illegal;

    modport master (
        output op, MemReady, FpDone,
        input  PCUpdate, IRWrite, RegWrite, FRegWrite, MemWrite, Branch, AdrSrc, FpStart,
        input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Illegal
    );

    modport slave (
        input  op, MemReady, FpDone,
        output PCUpdate, IRWrite, RegWrite, FRegWrite, MemWrite, Branch, AdrSrc, FpStart,
        output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Illegal
    );
endinterface

// File: rtl/mainfsm_f_fp_wdog.sv
// FPU wait counter: counts stalled FPEXEC cycles and flags the last allowed one.
module fp_wdog
    import mainfsm_pkg::*;
#(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clr)     r_count <= '0;
        else if (en) r_count <= r_count + CNT_W'(1);
    end

    assign expired = (r_count == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/mainfsm_f.sv
// Multicycle RV32I+F main control FSM with FPU watchdog and sticky illegal trap.
module mainfsm_f
    import mainfsm_pkg::*;
#(
    parameter int unsigned FP_EN      = 1,
    parameter int unsigned FP_TIMEOUT = 32
) (
    input  logic     clk,
    input  logic     reset,
    mainfsm_if.slave bus
);
    localparam bit FP_ON = (FP_EN != 0);

    state_t r_state, w_next;
    ctrl_t  r_ctrl, w_next_ctrl;
    logic   w_wdog_clr, w_wdog_en, w_expired, w_fetch_gate;

    assign w_wdog_clr = reset | (r_state != S_FPEXEC);
    assign w_wdog_en  = (r_state == S_FPEXEC) & ~bus.FpDone;

    fp_wdog #(.TIMEOUT(FP_TIMEOUT)) u_wdog (
        .clk     (clk),
        .clr     (w_wdog_clr),
        .en      (w_wdog_en),
        .expired (w_expired)
    );

    // State and decoded controls are registered together from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= state_ctrl(S_FETCH, '0);
        end else begin
            r_state <= w_next;
            r_ctrl  <= w_next_ctrl;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_next_ctrl = '0;
        case (r_state)
            S_FETCH:  if (bus.MemReady) w_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_FLW, OP_FSW:    w_next = FP_ON ? S_MEMADR : S_ILLEGAL;
                    OP_RTYPE:          w_next = S_EXECUTER;
                    OP_ITYPE:          w_next = S_EXECUTEI;
                    OP_JAL:            w_next = S_JAL;
                    OP_BEQ:            w_next = S_BEQ;
                    OP_LUI:            w_next = S_LUI;
                    OP_FP:             w_next = FP_ON ? S_FPEXEC : S_ILLEGAL;
                    default:           w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   w_next = (bus.op == OP_LOAD || bus.op == OP_FLW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (bus.MemReady) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (bus.MemReady) w_next = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_LUI, S_JAL: w_next = S_ALUWB;
            S_ALUWB, S_BEQ, S_FPWB:               w_next = S_FETCH;
            // A completing FPU wins over a coincident timeout.
            S_FPEXEC: begin
                if (bus.FpDone)     w_next = S_FPWB;
                else if (w_expired) w_next = S_ILLEGAL;
            end
            S_ILLEGAL:  w_next = S_ILLEGAL;
            default:    w_next = S_ILLEGAL;
        endcase
        w_next_ctrl          = state_ctrl(w_next, bus.op);
        w_next_ctrl.fp_start = (w_next == S_FPEXEC) && (r_state != S_FPEXEC);
    end

    assign w_fetch_gate = (r_state == S_FETCH) ? bus.MemReady : 1'b1;

    // Reset masks every strobe and parks the selects at their FETCH values.
    assign bus.PCUpdate  = ~reset & r_ctrl.pc_update & w_fetch_gate;
    assign bus.IRWrite   = ~reset & r_ctrl.ir_write & w_fetch_gate;
    assign bus.RegWrite  = ~reset & r_ctrl.reg_write;
    assign bus.FRegWrite = ~reset & r_ctrl.freg_write;
    assign bus.MemWrite  = ~reset & r_ctrl.mem_write;
    assign bus.Branch    = ~reset & r_ctrl.branch;
    assign bus.AdrSrc    = ~reset & r_ctrl.adr_src;
    assign bus.FpStart   = ~reset & r_ctrl.fp_start;
    assign bus.Illegal   = ~reset & r_ctrl.illegal;
    assign bus.ResultSrc = reset ? 2'b10   : r_ctrl.result_src;
    assign bus.ALUSrcA   = reset ? SRCA_PC : r_ctrl.alu_src_a;
    assign bus.ALUSrcB   = reset ? 2'b10   : r_ctrl.alu_src_b;
    assign bus.ALUOp     = reset ? 2'b00   : r_ctrl.alu_op;
endmodule
